// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/mult_dp.sv
// Datapath of the shift-add multiplier.
// Holds the operand magnitudes, the sign flag, the accumulator and the product register.
module mult_dp
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 write,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 mplr_zero,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    // Negating the most negative value wraps back to 2^(WIDTH-1).
    // That is the correct magnitude when the result is read as unsigned.
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    assign mplr_zero = (mplr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mcand <= {{WIDTH{1'b0}}, a_mag};
                mplr  <= b_mag;
                acc   <= '0;
                neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                if (mplr[0])
                    acc <= acc + mcand;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
            end
            if (write)
                product <= neg ? -acc : acc;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential multiplier for signed or unsigned operands.
// It ends early once the remaining multiplier bits are zero.
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t state;
    state_t next_state;
    logic   load;
    logic   step;
    logic   write;
    logic   mplr_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        write      = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (mplr_zero) begin
                    write      = 1'b1;
                    next_state = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .write       (write),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .mplr_zero   (mplr_zero),
        .product     (product)
    );

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=16).
// Uses directed corner cases, a mid-operation reset and randomized operations.
module tb_seq_mult;

    localparam int unsigned WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int checks   = 0;
    int failures = 0;
    logic [2*WIDTH-1:0] prev_product = '0;

    seq_mult #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [WIDTH-1:0] v, input bit sm);
        if (sm)
            return longint'($signed(v));
        return longint'({48'd0, v});
    endfunction

    // Bit length of |b| sets the number of shift steps before early exit.
    function automatic int bitlen(input logic [WIDTH-1:0] v, input bit sm);
        longint m;
        int     k;
        m = sx(v, sm);
        if (m < 0)
            m = -m;
        k = 0;
        while (m > 0) begin
            k++;
            m = m >> 1;
        end
        return k;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input bit sm, input bit hold, input string tag);
        logic [2*WIDTH-1:0] expv;
        int  k;
        bit  seen;
        @(negedge clk);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_done"}, done, 0);
        a           = ia;
        b           = ib;
        signed_mode = sm;
        start       = 1'b1;
        expv = (2*WIDTH)'(sx(ia, sm) * sx(ib, sm));
        k    = bitlen(ib, sm);
        @(posedge clk);
        #1;
        if (!hold)
            start = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        seen = 0;
        for (int n = 1; n <= int'(WIDTH) + 3 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({tag, " done_cycle"}, n, k + 2);
                check({tag, " product"}, product, expv);
                prev_product = expv;
            end else begin
                check({tag, " busy"}, busy, 1);
                check({tag, " product_hold"}, product, prev_product);
            end
        end
        if (!seen)
            check({tag, " done_timeout"}, 0, 1);
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        #3;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd3,    16'd5,    1'b0, 1'b0, "u3x5");
        run_op(16'd1234, 16'd0,    1'b0, 1'b0, "u1234x0");
        run_op(16'hFFFD, 16'd7,    1'b1, 1'b0, "sm3x7");
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, "smin_sq");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "umax_hold");
        run_op(16'h0007, 16'hFFFF, 1'b1, 1'b0, "s7xm1");

        // Reset in the fourth cycle of a long operation aborts it.
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort product", product, 0);
        #1 rst = 1'b0;
        prev_product = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort no_done", {busy, done}, 2'b00);
        end
        run_op(16'd2, 16'd3, 1'b0, 1'b0, "u2x3");

        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom) & WIDTH'((32'd1 << $urandom_range(0, 16)) - 1);
            run_op(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0), "rand");
        end

        @(negedge clk);
        check("final busy", busy, 0);
        check("final done", done, 0);
        check("final product", product, prev_product);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
